// File: rtl/scan_chain_ctrl_pkg.sv
// scan_ctrl_pkg: shared FSM states, MISR width/polynomial and MISR step function
package scan_ctrl_pkg;
    localparam int SIG_W = 16;
    localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;
    typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FIN} scan_state_e;
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig, input logic din);
        return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0) ^ {{(SIG_W-1){1'b0}}, din};
    endfunction
endpackage

// File: rtl/scan_chain_ctrl_if.sv
// scan_chain_ctrl_if: control, pattern and scan-chain signals of the scan controller
interface scan_chain_ctrl_if import scan_ctrl_pkg::*; #(parameter int CHAIN_LEN = 16);
    logic                 START;
    logic                 ABORT;
    logic [CHAIN_LEN-1:0] PAT_IN;
    logic                 SO;
    logic                 SE;
    logic                 SI;
    logic                 BUSY;
    logic                 DONE;
    logic [CHAIN_LEN-1:0] RESP;
    logic [SIG_W-1:0]     SIG;
    modport master (output START, ABORT, PAT_IN, SO, input SE, SI, BUSY, DONE, RESP, SIG);
    modport slave  (input START, ABORT, PAT_IN, SO, output SE, SI, BUSY, DONE, RESP, SIG);
endinterface

// File: rtl/scan_chain_ctrl_misr.sv
// scan_misr: 16-bit multiple-input signature register over the serial scan-out stream
module scan_misr import scan_ctrl_pkg::*; (
    input  logic             CLK,
    input  logic             RN,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);
    // clear wins over update so a new sequence always starts from a zero signature
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) sig <= '0;
        else if (clr) sig <= '0;
        else if (en) sig <= misr_step(sig, din);
    end
endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: load / capture / unload sequencer for an external scan chain with MISR compaction
module scan_chain_ctrl import scan_ctrl_pkg::*; #(
    parameter int CHAIN_LEN = 16
) (
    input  logic            CLK,
    input  logic            RN,
    scan_chain_ctrl_if.slave bus
);
    localparam int CW = $clog2(CHAIN_LEN);
    localparam logic [2:0] ST_IDLE      = IDLE;
    localparam logic [2:0] ST_SHIFT_IN  = SHIFT_IN;
    localparam logic [2:0] ST_CAPTURE   = CAPTURE;
    localparam logic [2:0] ST_SHIFT_OUT = SHIFT_OUT;
    localparam logic [2:0] ST_FIN       = FIN;

    logic [2:0]           state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [CHAIN_LEN-1:0] pat, pat_nxt;
    logic                 accept, last, shift_en;

    assign bus.BUSY = state == ST_SHIFT_IN || state == ST_CAPTURE || state == ST_SHIFT_OUT;
    assign bus.DONE = state == ST_FIN;

    // next state; ABORT dominates START and every busy-state transition
    always_comb begin
        accept   = (state == ST_IDLE || state == ST_FIN) && bus.START && !bus.ABORT;
        last     = cnt == CW'(CHAIN_LEN - 1);
        shift_en = state == ST_SHIFT_OUT && !bus.ABORT;
        pat_nxt  = accept ? bus.PAT_IN : pat;
        state_nxt = state;
        case (state)
            ST_IDLE, ST_FIN: state_nxt = accept ? ST_SHIFT_IN : ST_IDLE;
            ST_SHIFT_IN:     state_nxt = bus.ABORT ? ST_IDLE : last ? ST_CAPTURE : ST_SHIFT_IN;
            ST_CAPTURE:      state_nxt = bus.ABORT ? ST_IDLE : ST_SHIFT_OUT;
            ST_SHIFT_OUT:    state_nxt = bus.ABORT ? ST_IDLE : last ? ST_FIN : ST_SHIFT_OUT;
            default:         state_nxt = ST_IDLE;
        endcase
        cnt_nxt = (state_nxt == state && (state == ST_SHIFT_IN || state == ST_SHIFT_OUT)) ? cnt + CW'(1) : '0;
    end

    // SE/SI are registered from the next state so they line up with the state they belong to
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            pat      <= '0;
            bus.SE   <= 1'b0;
            bus.SI   <= 1'b0;
            bus.RESP <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pat      <= pat_nxt;
            bus.SE   <= state_nxt == ST_SHIFT_IN || state_nxt == ST_SHIFT_OUT;
            bus.SI   <= state_nxt == ST_SHIFT_IN && pat_nxt[CW'(CHAIN_LEN - 1) - cnt_nxt];
            bus.RESP <= accept ? '0 : shift_en ? {bus.RESP[CHAIN_LEN-2:0], bus.SO} : bus.RESP;
        end
    end

    scan_misr u_misr (
        .CLK (CLK),
        .RN  (RN),
        .clr (accept),
        .en  (shift_en),
        .din (bus.SO),
        .sig (bus.SIG)
    );
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: scoreboard bench driving scan_chain_ctrl against a 4-flop scan chain model
module tb_scan_chain_ctrl;
    typedef struct {
        logic [3:0]  resp;
        logic [15:0] sig;
    } exp_t;

    logic clk = 1'b0;
    logic rn  = 1'b0;
    logic [3:0] q = '0;
    logic [3:0] chain_d = '0;
    logic hold_m = 1'b0;
    int total = 0;
    int bad = 0;
    exp_t exp_q[$];

    scan_chain_ctrl_if #(.CHAIN_LEN(4)) bus ();

    scan_chain_ctrl #(.CHAIN_LEN(4)) dut (
        .CLK (clk),
        .RN  (rn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) q <= bus.SE ? {q[2:0], bus.SI} : (hold_m ? q : chain_d);
    assign bus.SO = q[3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [3:0] pat, input logic [3:0] d, input bit hold);
        exp_t e;
        e.resp = hold ? pat : d;
        e.sig = '0;
        for (int i = 3; i >= 0; i--)
            e.sig = {e.sig[14:0], 1'b0} ^ (e.sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, e.resp[i]};
        exp_q.push_back(e);
        bus.START = 1'b1;
        bus.PAT_IN = pat;
        chain_d = d;
        hold_m = hold;
        step();
        bus.START = 1'b0;
    endtask

    task automatic check_body(input logic [3:0] pat, input bit poke);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bus.SE !== 1'b1 || bus.SI !== pat[3-k] || bus.BUSY !== 1'b1) begin
                bad++;
                $display("FAIL shift_in[%0d]: SE=%b SI=%b BUSY=%b, expected SE=1 SI=%b BUSY=1", k, bus.SE, bus.SI, bus.BUSY, pat[3-k]);
            end
            if (poke && k == 1) begin
                bus.START = 1'b1;
                bus.PAT_IN = ~pat;
            end
            step();
            bus.START = 1'b0;
        end
        total++;
        if (bus.SE !== 1'b0 || bus.SI !== 1'b0 || bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
            bad++;
            $display("FAIL capture: SE=%b SI=%b BUSY=%b DONE=%b, expected 0 0 1 0", bus.SE, bus.SI, bus.BUSY, bus.DONE);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bus.SE !== 1'b1 || bus.SI !== 1'b0 || bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
                bad++;
                $display("FAIL shift_out[%0d]: SE=%b SI=%b BUSY=%b DONE=%b, expected 1 0 1 0", k, bus.SE, bus.SI, bus.BUSY, bus.DONE);
            end
            step();
        end
        total++;
        if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0 || bus.SE !== 1'b0) begin
            bad++;
            $display("FAIL fin: DONE=%b BUSY=%b SE=%b, expected 1 0 0", bus.DONE, bus.BUSY, bus.SE);
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: empty at DONE, expected one entry");
        end else begin
            e = exp_q.pop_front();
            if (bus.RESP !== e.resp || bus.SIG !== e.sig) begin
                bad++;
                $display("FAIL result: RESP=%b SIG=%h, expected RESP=%b SIG=%h", bus.RESP, bus.SIG, e.resp, e.sig);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        total++;
        if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || bus.SE !== 1'b0 || bus.SI !== 1'b0) begin
            bad++;
            $display("FAIL %s: DONE=%b BUSY=%b SE=%b SI=%b, expected all 0", tag, bus.DONE, bus.BUSY, bus.SE, bus.SI);
        end
    endtask

    task automatic test_reset();
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        bus.PAT_IN = '0;
        rn = 1'b0;
        repeat (2) step();
        total++;
        if (bus.SE !== 1'b0 || bus.SI !== 1'b0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.RESP !== 4'b0 || bus.SIG !== 16'h0) begin
            bad++;
            $display("FAIL reset: SE=%b SI=%b BUSY=%b DONE=%b RESP=%b SIG=%h, expected all 0", bus.SE, bus.SI, bus.BUSY, bus.DONE, bus.RESP, bus.SIG);
        end
        rn = 1'b1;
        step();
        check_idle("post_reset_idle");
    endtask

    task automatic test_load_capture();
        start_seq(4'b1101, 4'b0110, 1'b0);
        check_body(4'b1101, 1'b0);
        step();
        check_idle("after_done_basic");
    endtask

    task automatic test_hold();
        start_seq(4'b1001, 4'b0000, 1'b1);
        check_body(4'b1001, 1'b0);
        step();
        hold_m = 1'b0;
    endtask

    task automatic test_misr();
        start_seq(4'b0101, 4'b1000, 1'b0);
        check_body(4'b0101, 1'b0);
        total++;
        if (bus.SIG !== 16'h0008) begin
            bad++;
            $display("FAIL misr_1000: SIG=%h, expected 0008", bus.SIG);
        end
        step();
    endtask

    task automatic test_back_to_back();
        start_seq(4'b0101, 4'b0011, 1'b0);
        check_body(4'b0101, 1'b1);
        start_seq(4'b1110, 4'b1100, 1'b0);
        check_body(4'b1110, 1'b0);
        step();
        check_idle("after_back_to_back");
    endtask

    task automatic test_abort();
        bit seen;
        start_seq(4'b0111, 4'b1000, 1'b0);
        repeat (6) step();
        bus.ABORT = 1'b1;
        bus.START = 1'b1;
        step();
        bus.ABORT = 1'b0;
        bus.START = 1'b0;
        check_idle("abort_next");
        total++;
        if (bus.RESP !== 4'b0001 || bus.SIG !== 16'h0001) begin
            bad++;
            $display("FAIL abort_partial: RESP=%b SIG=%h, expected RESP=0001 SIG=0001", bus.RESP, bus.SIG);
        end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_quiet: DONE or BUSY seen=1, expected 0");
        end
        void'(exp_q.pop_back());
    endtask

    task automatic test_abort_start_idle();
        bus.ABORT = 1'b1;
        bus.START = 1'b1;
        bus.PAT_IN = 4'b1111;
        step();
        bus.ABORT = 1'b0;
        bus.START = 1'b0;
        check_idle("abort_start_idle");
        step();
        check_idle("abort_start_idle_2");
    endtask

    task automatic test_rst_mid();
        bit seen;
        start_seq(4'b1111, 4'b0110, 1'b0);
        repeat (2) step();
        #2;
        rn = 1'b0;
        #1;
        total++;
        if (bus.SE !== 1'b0 || bus.SI !== 1'b0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.RESP !== 4'b0 || bus.SIG !== 16'h0) begin
            bad++;
            $display("FAIL async_reset: SE=%b SI=%b BUSY=%b DONE=%b RESP=%b SIG=%h, expected all 0", bus.SE, bus.SI, bus.BUSY, bus.DONE, bus.RESP, bus.SIG);
        end
        @(posedge clk);
        #2;
        rn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL reset_no_done: DONE or BUSY seen=1, expected 0");
        end
        void'(exp_q.pop_back());
    endtask

    initial begin
        test_reset();
        test_load_capture();
        test_hold();
        test_misr();
        test_back_to_back();
        test_abort();
        test_abort_start_idle();
        test_rst_mid();
        test_load_capture();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 Parameter: CHAIN_LEN, default 16, number of scan flops in the driven chain (legal 2..1024).
REQ-002 Parameter: SIG_W, fixed 16, MISR signature width (set by the shared package constant).
REQ-003 Ports, one per line: name  direction  width  meaning.
REQ-004 CLK  in  1  single clock; also clocks the scan chain, which samples on the rising edge.
REQ-005 RN  in  1  asynchronous active-low reset.
REQ-006 START  in  1  request one load/capture/unload test sequence.
REQ-007 ABORT  in  1  synchronous cancel of a running sequence.
REQ-008 PAT_IN  in  CHAIN_LEN  pattern to load; bit i ends up in chain flop i.
REQ-009 SO  in  1  scan-out from chain flop CHAIN_LEN-1.
REQ-010 SE  out  1  scan enable to every chain flop; registered.
REQ-011 SI  out  1  scan-in to chain flop 0; registered.
REQ-012 BUSY  out  1  sequence in progress.
REQ-013 DONE  out  1  one-cycle completion pulse.
REQ-014 RESP  out  CHAIN_LEN  unloaded capture data; bit i holds captured flop i.
REQ-015 SIG  out  SIG_W  MISR signature of the unloaded SO stream.

Function
REQ-016 FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FIN.
REQ-017 IDLE or FIN with START=1 and ABORT=0: latch PAT_IN, clear RESP and SIG to 0, reset counter to 0, go to SHIFT_IN.
REQ-018 SHIFT_IN: SE=1 and SI=PAT_IN_latched[CHAIN_LEN-1-cnt] for exactly CHAIN_LEN cycles (MSB first), then go to CAPTURE.
REQ-019 CAPTURE: SE=0 and SI=0 for exactly one cycle, then go to SHIFT_OUT with counter reset to 0.
REQ-020 SHIFT_OUT: SE=1 and SI=0 for exactly CHAIN_LEN cycles.
REQ-021 SHIFT_OUT capture: at each rising edge, RESP <= {RESP[CHAIN_LEN-2:0], SO} and the MISR is updated with the SO value present before the chain shifts.
REQ-022 SHIFT_OUT exit: after the last edge, go to FIN.
REQ-023 MISR update: SIG <= {SIG[14:0],1'b0} ^ (SIG[15] ? POLY : 0) ^ {15'b0, SO}, with POLY = 16'h1021.
REQ-024 FIN lasts one cycle with DONE=1, SE=0, BUSY=0, then goes to IDLE unless a new START is accepted.
REQ-025 BUSY=1 exactly in SHIFT_IN, CAPTURE and SHIFT_OUT.
REQ-026 START is ignored while BUSY=1.
REQ-027 ABORT=1 in any busy state: go to IDLE on the next edge; SE=0 and SI=0 from that edge; no DONE pulse; RESP and SIG hold their partial values.
REQ-028 START and ABORT asserted together: ABORT wins; the block stays in or enters IDLE.
REQ-029 Counter width is clog2(CHAIN_LEN); it SHALL not wrap within a phase.
REQ-030 Total sequence length is 2*CHAIN_LEN+1 cycles from the first SE=1 cycle to the FIN cycle, exclusive.

Reset
REQ-031 RN=0 SHALL immediately force state=IDLE, SE=0, SI=0, BUSY=0, DONE=0, RESP=0, SIG=0 and counter=0, independent of CLK.
REQ-032 RN asserted mid-sequence SHALL abandon the sequence with no DONE pulse; operation resumes only on a new START after RN deasserts.

Structure
REQ-033 Package scan_ctrl_pkg SHALL hold the FSM state enum, SIG_W=16 and MISR_POLY=16'h1021.
REQ-034 The MISR SHALL be a separate sub-module, scan_misr, with ports CLK, RN, clr, en, din and sig.
REQ-035 The chain is external to this block; SE, SI and SO connect directly to the scan flop cells.

Verification (bench: CHAIN_LEN=4, chain of 4 scan flops with a settable D bus)
REQ-036 RN pulse low mid-SHIFT_IN: SE=0, SI=0, BUSY=0, RESP=0, SIG=0 with no clock edge; no DONE follows.
REQ-037 PAT_IN=4'b1101 with chain D=4'b0110: SI=1,1,0,1 with SE=1 for 4 cycles, then SE=0 for 1 cycle, then SE=1 for 4 cycles, then DONE; RESP=4'b0110.
REQ-038 Chain D wired to own Q (hold) with PAT_IN=4'b1001: RESP=4'b1001 at DONE.
REQ-039 SO stream 1,0,0,0 with chain D=4'b1000: SIG=16'h0008 at DONE.
REQ-040 ABORT on the 2nd SHIFT_OUT cycle: SE=0 on the next cycle, no DONE, BUSY=0; START in that same cycle is ignored.
REQ-041 START pulsed during SHIFT_IN: no effect; START asserted in the FIN cycle: new SHIFT_IN begins on the next cycle.
